// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU instruction-fetch stage.
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BR   = 2'b10,
        PS_JMP  = 2'b11
    } ps_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] sext6(input logic [5:0] v);
        return {{(INSTR_W-6){v[5]}}, v};
    endfunction

endpackage

// File: rtl/cpu_pc_next.sv
// Combinational next-PC selector driven by the decoder's PS control.
module cpu_pc_next
    import cpu_pkg::*;
(
    input  logic [15:0] pc,
    input  logic [1:0]  ps,
    input  logic [5:0]  br_ofs,
    input  logic [15:0] jump_target,
    output logic [15:0] pc_next
);

    // All adds are 16-bit so wrap-around falls out naturally.
    always_comb begin
        pc_next = pc;
        case (ps_e'(ps))
            PS_HOLD: pc_next = pc;
            PS_INC:  pc_next = pc + 16'd1;
            PS_BR:   pc_next = pc + sext6(br_ofs);
            PS_JMP:  pc_next = jump_target;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch/sequencing stage: owns PC, IR and the execution-state bit.
// Optional fetch timeout enabled by defining CPU_FETCH_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_FETCH | request word at pc, wait for imem_ack
// ST_EXEC  | IR valid to decoder, apply ps/ns/ir_l
// ST_HALT  | stopped, pc/ir frozen until reset
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ps,
    input  logic        ir_l,
    input  logic        ns,
    input  logic [15:0] jump_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] ir,
    output logic        state,
    output logic [15:0] pc,
    output logic        ir_valid,
    output logic        halted,
    output logic        fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_e fsm_q, fsm_d;
    logic [15:0]  pc_q, ir_q, pc_next;
    logic         state_q;
    logic         tmo_hit;

    cpu_pc_next u_pc_next (
        .pc          (pc_q),
        .ps          (ps),
        .br_ofs      ({ir_q[8:6], ir_q[2:0]}),
        .jump_target (jump_target),
        .pc_next     (pc_next)
    );

`ifdef CPU_FETCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        fetch_err_q;

    assign tmo_hit = (fsm_q == ST_FETCH) && !imem_ack && (tmo_cnt == 16'd0);

    // Down-counter reloads whenever we are outside FETCH, so it starts fresh on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= TMO_LOAD;
            fetch_err_q <= 1'b0;
        end else begin
            if (fsm_q != ST_FETCH)
                tmo_cnt <= TMO_LOAD;
            else if (!imem_ack && tmo_cnt != 16'd0)
                tmo_cnt <= tmo_cnt - 16'd1;
            if (tmo_hit)
                fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fsm_q <= ST_FETCH;
        else
            fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_FETCH: if (imem_ack || tmo_hit) fsm_d = ST_EXEC;
            ST_EXEC: begin
                if (ns)        fsm_d = ST_EXEC;
                else if (ir_l) fsm_d = ST_FETCH;
                else           fsm_d = ST_HALT;
            end
            ST_HALT:  fsm_d = ST_HALT;
            default:  fsm_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        halted   = 1'b0;
        case (fsm_q)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC:  ir_valid = 1'b1;
            ST_HALT:  halted   = 1'b1;
            default:  imem_req = 1'b0;
        endcase
    end

    // IR is written only in FETCH; PC only moves in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            state_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= 1'b0;
                    end else if (tmo_hit) begin
                        ir_q    <= 16'h0000;
                        state_q <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    pc_q    <= pc_next;
                    state_q <= ns;
                end
                default: ;
            endcase
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed self-checking bench for cpu_fetch_unit (honours CPU_FETCH_TIMEOUT_EN).
module tb_cpu_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk, rst_n;
    logic [1:0]  ps;
    logic        ir_l, ns;
    logic [15:0] jump_target;
    logic        imem_req;
    logic [15:0] imem_addr, imem_rdata;
    logic        imem_ack;
    logic [15:0] ir;
    logic        state;
    logic [15:0] pc;
    logic        ir_valid, halted, fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    cpu_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ps(ps), .ir_l(ir_l), .ns(ns),
        .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .ir(ir), .state(state),
        .pc(pc), .ir_valid(ir_valid), .halted(halted), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] word);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(addr));
        check("fetch_not_valid", 32'(ir_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check("exec_valid", 32'(ir_valid), 32'd1);
        check("exec_ir", 32'(ir), 32'(word));
        check("exec_state", 32'(state), 32'd0);
        check("exec_pc", 32'(pc), 32'(addr));
    endtask

    task automatic exec(input logic [1:0] p, input logic n, input logic l, input logic [15:0] jt);
        ps = p; ns = n; ir_l = l; jump_target = jt;
        step();
        ps = 2'b00; ns = 1'b0; ir_l = 1'b0; jump_target = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0; ps = 2'b00; ir_l = 1'b0; ns = 1'b0;
        jump_target = 16'h0000; imem_ack = 1'b0; imem_rdata = 16'h0000;
        step(); step();
        check("rst_pc", 32'(pc), 32'(RST_PC));
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;

        // sequential fetch, one instruction per two cycles
        for (int i = 0; i < 4; i++) begin
            fetch_one(16'(i), 16'h1000 + 16'(i));
            exec(2'b01, 1'b0, 1'b1, 16'h0000);
        end

        // jump, branch -2, branch +5, increment wrap, branch wrap below zero
        fetch_one(16'h0004, 16'h2000);
        exec(2'b11, 1'b0, 1'b1, 16'h0010);
        fetch_one(16'h0010, 16'h01C6);
        exec(2'b10, 1'b0, 1'b1, 16'h0000);
        fetch_one(16'h000E, 16'h0005);
        exec(2'b10, 1'b0, 1'b1, 16'h0000);
        fetch_one(16'h0013, 16'h3000);
        exec(2'b11, 1'b0, 1'b1, 16'hFFFF);
        fetch_one(16'hFFFF, 16'h0007);
        exec(2'b01, 1'b0, 1'b1, 16'h0000);
        fetch_one(16'h0000, 16'h01C6);
        exec(2'b10, 1'b0, 1'b1, 16'h0000);
        fetch_one(16'hFFFE, 16'h4444);

        // multi-cycle instruction with a stray ack during EXEC
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        ps = 2'b00; ns = 1'b1; ir_l = 1'b0;
        step();
        check("mc_state1", 32'(state), 32'd1);
        check("mc_valid1", 32'(ir_valid), 32'd1);
        check("mc_ir1", 32'(ir), 32'h4444);
        check("mc_pc1", 32'(pc), 32'hFFFE);
        check("mc_req1", 32'(imem_req), 32'd0);
        ps = 2'b01; ns = 1'b0; ir_l = 1'b1;
        step();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        ps = 2'b00; ns = 1'b0; ir_l = 1'b0;
        check("mc_state2", 32'(state), 32'd0);
        check("mc_ir2", 32'(ir), 32'h4444);
        check("mc_valid2", 32'(ir_valid), 32'd0);
        fetch_one(16'hFFFF, 16'h5555);

        // halt: pc takes the final update then freezes
        exec(2'b11, 1'b0, 1'b0, 16'h0123);
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", 32'(pc), 32'h0123);
            check("halt_ir", 32'(ir), 32'h5555);
            imem_ack = 1'b1; imem_rdata = 16'hAAAA;
            ps = 2'b11; jump_target = 16'h7777; ns = 1'b1; ir_l = 1'b1;
            step();
        end
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        ps = 2'b00; jump_target = 16'h0000; ns = 1'b0; ir_l = 1'b0;

        // reset leaves HALT
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_pc", 32'(pc), 32'(RST_PC));

        // reset asserted in the second cycle of a waiting fetch
        fetch_one(16'h0000, 16'h6666);
        exec(2'b11, 1'b0, 1'b1, 16'h0200);
        step();
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr", 32'(imem_addr), 32'h0200);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pc", 32'(pc), 32'(RST_PC));
        check("abort_ir", 32'(ir), 32'd0);
        check("abort_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        step();
        check("late_ack_ir", 32'(ir), 32'd0);
        check("late_ack_valid", 32'(ir_valid), 32'd0);
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        rst_n = 1'b1;
        fetch_one(RST_PC, 16'h0777);
        exec(2'b01, 1'b0, 1'b1, 16'h0000);

        // 16 cycles without ack
        for (int i = 0; i < 15; i++) begin
            step();
            check("noack_wait", 32'(ir_valid), 32'd0);
        end
        step();
`ifdef CPU_FETCH_TIMEOUT_EN
        check("tmo_valid", 32'(ir_valid), 32'd1);
        check("tmo_ir", 32'(ir), 32'd0);
        check("tmo_err", 32'(fetch_err), 32'd1);
        check("tmo_state", 32'(state), 32'd0);
        exec(2'b01, 1'b0, 1'b1, 16'h0000);
        check("tmo_err_sticky", 32'(fetch_err), 32'd1);
        check("tmo_next_addr", 32'(imem_addr), 32'h0002);
`else
        check("noack_valid", 32'(ir_valid), 32'd0);
        check("noack_req", 32'(imem_req), 32'd1);
        check("noack_addr", 32'(imem_addr), 32'h0001);
        check("noack_err", 32'(fetch_err), 32'd0);
        fetch_one(16'h0001, 16'h0888);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_unit.md
# cpu_fetch_unit

Instruction-fetch and sequencing stage that sits directly upstream of the CPU instruction decoder. It owns the program counter (PC), the instruction register (IR) and the execution-state bit, and fetches 16-bit instruction words over a request/acknowledge memory port. It presents IR and State to the decoder, then applies the decoder's PS, IR_L and NS controls to sequence the next PC and instruction.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYCLES, 16, fetch-timeout limit (used only with the timeout feature)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- ps  input  2  PC select from decoder: 00 hold, 01 increment, 10 branch relative, 11 jump
- ir_l  input  1  decoder request to fetch the next instruction at retire
- ns  input  1  decoder next execution state
- jump_target  input  16  absolute jump address (register A bus)
- imem_req  output  1  instruction-memory request
- imem_addr  output  16  instruction-memory address (always equals pc)
- imem_rdata  input  16  instruction word
- imem_ack  input  1  imem_rdata valid this cycle
- ir  output  16  instruction register to decoder
- state  output  1  execution state bit to decoder
- pc  output  16  current program counter
- ir_valid  output  1  high in EXEC; decoder outputs are meaningful only then
- halted  output  1  high in HALT
- fetch_err  output  1  sticky fetch-timeout flag (timeout build only; tied 0 otherwise)

## Operation
- FSM states: FETCH, EXEC, HALT. Reset enters FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_rdata, state<=0, next state EXEC. Without ack: remain in FETCH, hold request.
- EXEC: ir_valid=1; ps, ns, ir_l are sampled every EXEC cycle.
  - PC update each EXEC cycle: 00 pc; 01 pc+1; 10 pc+sext({ir[8:6],ir[2:0]}) (6-bit two's-complement offset); 11 jump_target.
  - ns=1: state<=1, remain in EXEC (multi-cycle instruction).
  - ns=0, ir_l=1: retire; state<=0, next state FETCH.
  - ns=0, ir_l=0: retire and stop; next state HALT.
- HALT: imem_req=0, pc/ir frozen; exited only by reset.
- imem_ack outside FETCH is ignored; ir is never written outside FETCH.
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 wraps to 16'h0000; branch offsets wrap both directions.

## Timing
- Reset values: pc=RESET_PC, ir=16'h0000, state=0, ir_valid=0, halted=0, imem_req=1 (FETCH), fetch_err=0.
- Zero-wait memory (ack in first FETCH cycle): 1 FETCH + 1 EXEC = 2 cycles per single-cycle instruction; each ns=1 adds one EXEC cycle; each wait cycle adds one FETCH cycle.
- imem_addr is stable for the whole request; imem_req drops the cycle after ack.
- Reset asserted mid-fetch or mid-execution aborts immediately; no partial IR/PC update survives.

## Configuration
- CPU_FETCH_TIMEOUT_EN defined: a counter runs in FETCH; if imem_ack is absent for TIMEOUT_CYCLES consecutive cycles, ir<=16'h0000, fetch_err<=1 (sticky until reset), FSM enters EXEC as if acked. Counter clears on entering FETCH.
- Undefined: no counter, FETCH waits indefinitely, fetch_err tied 0.

## Structure
- Shared package cpu_pkg: PS encodings (PS_HOLD, PS_INC, PS_BR, PS_JMP), fetch FSM state enum, instruction width constant 16.
- One sub-module: cpu_pc_next, combinational next-PC selector (pc, ps, ir offset field, jump_target -> next pc).

## Test plan
- Reset, zero-wait memory, ps=01/ir_l=1/ns=0 each EXEC -> imem_addr sequence 0,1,2,3, one instruction per 2 cycles.
- pc=16'h0010, ir[8:6]=3'b111, ir[2:0]=3'b110 (offset -2), ps=10 -> next fetch address 16'h000E; pc=16'hFFFF, ps=01 -> 16'h0000.
- ns=1 for one cycle then ns=0/ir_l=1 -> state 0->1->0, two EXEC cycles, ir unchanged, ack asserted during EXEC ignored.
- ir_l=0 with ns=0 -> halted=1, imem_req=0, pc frozen for 20 cycles.
- Ack delayed 3 cycles, rst_n pulsed low in cycle 2 -> pc=RESET_PC, ir=0, FETCH restarts, late ack from old request not loaded.
- CPU_FETCH_TIMEOUT_EN, no ack for 16 cycles -> ir=16'h0000, fetch_err=1, ir_valid=1 next cycle.
